// File: rtl/rs_station_param.sv
// Parametrised reservation station: holds renamed ops, snoops the CDB for operands,
// and issues the oldest ready entry to its functional unit.
module rs_station_param #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int FUNC_W = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [FUNC_W-1:0] disp_func,
  input  logic [TAG_W-1:0]  disp_rob,
  input  logic              disp_rs1_rdy,
  input  logic [DATA_W-1:0] disp_rs1_val,
  input  logic [TAG_W-1:0]  disp_rs1_tag,
  input  logic              disp_rs2_rdy,
  input  logic [DATA_W-1:0] disp_rs2_val,
  input  logic [TAG_W-1:0]  disp_rs2_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [FUNC_W-1:0] iss_func,
  output logic [DATA_W-1:0] iss_rs1,
  output logic [DATA_W-1:0] iss_rs2,
  output logic [TAG_W-1:0]  iss_rob,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshakes: a transfer happens on a posedge where valid && ready are both high.
  logic              busy_q    [DEPTH];
  logic [FUNC_W-1:0] func_q    [DEPTH];
  logic [TAG_W-1:0]  rob_q     [DEPTH];
  logic              rs1_rdy_q [DEPTH];
  logic [DATA_W-1:0] rs1_val_q [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_q [DEPTH];
  logic              rs2_rdy_q [DEPTH];
  logic [DATA_W-1:0] rs2_val_q [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_q [DEPTH];
  // older_q[i][j] = 1 when entry j was dispatched before entry i.
  logic [DEPTH-1:0]  older_q   [DEPTH];
  logic [CNT_W-1:0]  cnt_q;

  logic [DEPTH-1:0]  busy_vec;
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  sel_vec;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic              disp_fire;
  logic              iss_fire;
  logic              bp1_hit;
  logic              bp2_hit;

  assign count      = cnt_q;
  assign full       = (cnt_q == CNT_W'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign disp_ready = !full;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign iss_fire   = iss_valid && iss_ready;
  assign bp1_hit    = cdb_valid && (disp_rs1_tag == cdb_tag);
  assign bp2_hit    = cdb_valid && (disp_rs2_tag == cdb_tag);

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    sel_vec   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = busy_q[i];
      ready_vec[i] = busy_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i];
    end
    // Oldest ready entry: ready with no older ready entry.
    for (int i = 0; i < DEPTH; i++) begin
      sel_vec[i] = ready_vec[i] && ((older_q[i] & ready_vec) == '0);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    iss_valid = 1'b0;
    iss_func  = '0;
    iss_rs1   = '0;
    iss_rs2   = '0;
    iss_rob   = '0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_vec[i]) begin
        iss_valid = 1'b1;
        iss_func  = iss_func | func_q[i];
        iss_rs1   = iss_rs1 | rs1_val_q[i];
        iss_rs2   = iss_rs2 | rs2_val_q[i];
        iss_rob   = iss_rob | rob_q[i];
        sel_idx   = sel_idx | IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]    <= 1'b0;
        func_q[i]    <= '0;
        rob_q[i]     <= '0;
        rs1_rdy_q[i] <= 1'b0;
        rs1_val_q[i] <= '0;
        rs1_tag_q[i] <= '0;
        rs2_rdy_q[i] <= 1'b0;
        rs2_val_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        older_q[i]   <= '0;
      end
      cnt_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]  <= 1'b0;
        older_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && !rs1_rdy_q[i] && cdb_valid && rs1_tag_q[i] == cdb_tag) begin
          rs1_rdy_q[i] <= 1'b1;
          rs1_val_q[i] <= cdb_data;
        end
        if (busy_q[i] && !rs2_rdy_q[i] && cdb_valid && rs2_tag_q[i] == cdb_tag) begin
          rs2_rdy_q[i] <= 1'b1;
          rs2_val_q[i] <= cdb_data;
        end
      end
      if (iss_fire) busy_q[sel_idx] <= 1'b0;
      if (disp_fire) begin
        busy_q[free_idx]    <= 1'b1;
        func_q[free_idx]    <= disp_func;
        rob_q[free_idx]     <= disp_rob;
        rs1_rdy_q[free_idx] <= disp_rs1_rdy || bp1_hit;
        rs1_val_q[free_idx] <= disp_rs1_rdy ? disp_rs1_val : cdb_data;
        rs1_tag_q[free_idx] <= disp_rs1_tag;
        rs2_rdy_q[free_idx] <= disp_rs2_rdy || bp2_hit;
        rs2_val_q[free_idx] <= disp_rs2_rdy ? disp_rs2_val : cdb_data;
        rs2_tag_q[free_idx] <= disp_rs2_tag;
        // Newcomer is younger than everything resident; nobody is younger than it.
        older_q[free_idx]   <= busy_vec;
        for (int i = 0; i < DEPTH; i++) older_q[i][free_idx] <= 1'b0;
      end
      if (disp_fire && !iss_fire)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!disp_fire && iss_fire) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: doc/rs_station_param.md
Name: rs_station_param

Overview:
- Parametrised reservation station for the Tomasulo core. Replaces the fixed 3-entry add/mul arrays with one configurable-depth queue; each functional unit (add/sub, mul/div, branch, load/store) gets its own instance.
- Accepts renamed instructions from dispatch and holds operand values or ROB tags. Snoops the common data bus (CDB) to capture results.
- Issues the oldest fully-ready entry to its functional unit over a valid/ready handshake.
- Adds three capabilities the fixed arrays lacked: value capture, same-cycle CDB bypass, and flush.

Parameters:
DEPTH, 4, number of entries (2..16)
DATA_W, 16, operand/result width
TAG_W, 3, ROB index width
FUNC_W, 4, function code width
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk1  in  1  clock, all state changes on posedge
rst  in  1  synchronous active-high reset
flush  in  1  squash all entries (branch mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  entry available (= !full)
disp_func  in  FUNC_W  function code
disp_rob  in  TAG_W  destination ROB index
disp_rs1_rdy  in  1  1: disp_rs1_val is valid; 0: wait on disp_rs1_tag
disp_rs1_val  in  DATA_W  operand 1 value
disp_rs1_tag  in  TAG_W  operand 1 producer ROB tag
disp_rs2_rdy  in  1  as rs1
disp_rs2_val  in  DATA_W  as rs1
disp_rs2_tag  in  TAG_W  as rs1
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  ROB tag of broadcast result
cdb_data  in  DATA_W  broadcast result
iss_valid  out  1  a ready entry is presented
iss_ready  in  1  functional unit accepts
iss_func  out  FUNC_W  selected entry function code
iss_rs1  out  DATA_W  selected operand 1
iss_rs2  out  DATA_W  selected operand 2
iss_rob  out  TAG_W  selected destination ROB index
count  out  CNT_W  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset: one synchronous active-high clock/reset scheme. On rst, all entries are invalid and all age state is cleared. Reset values: count=0, empty=1, full=0, disp_ready=1, iss_valid=0, iss_* data outputs=0. rst mid-operation discards all entries, with no issue that cycle.
- Entry contents: busy, func, rob, and per operand {rdy, val, tag}, plus age rank.
- Dispatch: a dispatch is accepted when disp_valid && disp_ready at posedge. It writes the lowest-index free entry. disp_ready is based on occupancy at the start of the cycle; an entry freed by issue in the same cycle is not reusable until the next cycle.
- CDB capture: each cycle with cdb_valid, every busy operand with rdy=0 and tag==cdb_tag latches cdb_data and sets rdy=1.
- CDB bypass: if cdb_valid and cdb_tag matches a not-ready dispatch operand in the same cycle, that operand is written with rdy=1 and val=cdb_data.
- Selection: an entry is ready when busy && rs1.rdy && rs2.rdy. The selected entry is the oldest ready entry by dispatch order, not by index.
- Issue outputs: iss_valid and iss_* are combinational from current entry state.
  - iss_valid=0 implies iss_* = 0.
  - iss_valid && iss_ready at posedge frees the selected entry.
- Latency: dispatch with both operands ready at edge N gives iss_valid=1 in the cycle after edge N. A CDB wakeup at edge N gives the same.
- Backpressure: with iss_ready=0, the selected entry and iss_* stay stable unless an older entry becomes ready.
- Simultaneous events:
  - Dispatch and issue in the same cycle: count unchanged.
  - Dispatch when full: ignored, count unchanged.
- Flush: on posedge with flush=1, all entries are invalidated and count=0. A dispatch presented in the same cycle is dropped. An issue handshake in that cycle is still seen by the functional unit; squashing it is the ROB's job.
- count: +1 on accepted dispatch, -1 on issue handshake, saturates within 0..DEPTH by construction.
- ROB tags are unique among in-flight producers, so a CDB match needs no ordering resolution.

Test Plan:
- Reset then dispatch func=0, rob=2, rs1 val=5, rs2 val=7, both ready, iss_ready=1 -> next cycle iss_valid=1, iss_rs1=5, iss_rs2=7, iss_rob=2; following cycle count=0, empty=1.
- Dispatch rs1 tag=3 not ready; 2 cycles later cdb_valid, tag=3, data=0x00AA -> iss_valid=1 the cycle after the broadcast, iss_rs1=0x00AA.
- Dispatch with rs2 tag=5 not ready, in the same cycle as cdb tag=5 data=9 -> bypass, iss_valid next cycle, iss_rs2=9.
- iss_ready=0; dispatch DEPTH ready entries rob=0..3 -> full=1, disp_ready=0, extra dispatch ignored. Then iss_ready=1 -> issues rob 0,1,2,3 in order, one per cycle.
- Entry A (older, waiting on tag 1), entry B (younger, ready); B issues first; CDB tag 1 -> A issues next.
- 3 entries valid, assert flush with disp_valid=1 -> next cycle count=0, empty=1, iss_valid=0, and the dispatched instruction is absent.
